// File: rtl/lsu_pkg.sv
// Shared encodings for the byte-serial load/store unit: access sizes, FSM states
// and the per-size beat count.
package lsu_pkg;

    localparam logic [1:0] SIZE_B   = 2'd0;
    localparam logic [1:0] SIZE_H   = 2'd1;
    localparam logic [1:0] SIZE_W   = 2'd2;
    localparam logic [1:0] SIZE_RSV = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Index of the final byte beat for an access size (n - 1).
    function automatic logic [1:0] last_beat(input logic [1:0] size);
        case (size)
            SIZE_H:  return 2'd1;
            SIZE_W:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load-data extension: sign- or zero-fills byte and half loads to
// 32 bits; words pass through, the reserved size yields zero.
module lsu_load_ext (
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);
    import lsu_pkg::*;

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] byte_sx;
    logic signed [31:0] half_sx;

    assign byte_s  = data[7:0];
    assign half_s  = data[15:0];
    assign byte_sx = byte_s;
    assign half_sx = half_s;

    always_comb begin
        result = '0;
        case (size)
            SIZE_B:  result = is_unsigned ? {24'd0, data[7:0]}  : byte_sx;
            SIZE_H:  result = is_unsigned ? {16'd0, data[15:0]} : half_sx;
            SIZE_W:  result = data;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit bridging 32-bit CPU requests onto a byte-wide memory, one byte
// per cycle, little-endian, with a one-cycle completion pulse.
module lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic        mem_re,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);
    import lsu_pkg::*;

    state_t      state;
    logic [1:0]  cnt;
    logic [1:0]  cnt_nx;
    logic [1:0]  last;
    logic [1:0]  cap_idx;
    logic        cap_vld_p1;
    logic        accept;

    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf;
    logic [31:0] asm_data;
    logic [31:0] ext_data;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign cnt_nx    = cnt + 2'd1;

    // A read byte arrives the cycle after its strobe; merge it in flight so the
    // final byte can feed the extender in the same cycle it lands.
    always_comb begin
        asm_data = rbuf;
        if (cap_vld_p1)
            asm_data[{cap_idx, 3'b000} +: 8] = mem_rdata;
    end

    lsu_load_ext u_ext (
        .data        (asm_data),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (ext_data)
    );

    // Request fields and read assembly buffer
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            last    <= last_beat(req_size);
            rbuf    <= '0;
        end else if (cap_vld_p1) begin
            rbuf    <= asm_data;
        end
    end

    // Control FSM with registered memory and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            cap_idx    <= '0;
            cap_vld_p1 <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            resp_valid <= 1'b0;
            cap_vld_p1 <= mem_re;
            if (cap_vld_p1)
                cap_idx <= cap_idx + 2'd1;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cnt     <= '0;
                        cap_idx <= '0;
                        if (req_size == SIZE_RSV) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state     <= ST_XFER;
                            mem_addr  <= req_addr;
                            mem_we    <= req_we;
                            mem_re    <= !req_we;
                            mem_wdata <= req_we ? req_wdata[7:0] : 8'd0;
                        end
                    end
                end

                ST_XFER: begin
                    if (cnt == last) begin
                        mem_addr  <= '0;
                        mem_we    <= 1'b0;
                        mem_re    <= 1'b0;
                        mem_wdata <= '0;
                        if (we_q) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= '0;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end else begin
                        cnt       <= cnt_nx;
                        mem_addr  <= addr_q + {30'd0, cnt_nx};
                        mem_wdata <= we_q ? wdata_q[{cnt_nx, 3'b000} +: 8] : 8'd0;
                    end
                end

                ST_WAIT: begin
                    state      <= ST_RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= ext_data;
                end

                ST_RESP: state <= ST_IDLE;

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
